// File: rtl/psum_accumulator_pkg.sv
// Shared definitions for the partial-sum accumulator and the array top.
//   psum_width(size) : width of one column partial sum leaving the array
//   acc_width(pw)    : accumulator lane width (4 guard bits over the column sum)
//   lane_lsb(l, w)   : LSB of lane l in a flat packed lane bus
//   PSUM_LANE(c, w)  : part-select body for lane c of width w in a flat bus
`ifndef PSUM_LANE
`define PSUM_LANE(c, w) (c)*(w) +: (w)
`endif

package psum_accumulator_pkg;

  // 8b x 4b products, 4 bits of in-column growth, plus log2 of the column count.
  function automatic int psum_width(input int size);
    return 8 + 4 + 4 + $clog2(size);
  endfunction

  function automatic int acc_width(input int pw);
    return pw + 4;
  endfunction

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/psum_out_fifo.sv
// Two-entry first-word-fall-through output FIFO with a sticky overflow flag.
//   push/push_data : write a finished row (dropped if full and not popping)
//   out_data       : head register, valid while out_valid
//   out_ready      : consumer takes the head when out_valid && out_ready
//   overflow       : set when a push is dropped, held until rst
module psum_out_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow
);

  logic [WIDTH-1:0] head_q, tail_q;
  logic [1:0]       count_q;
  logic             pop, accept;

  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign accept    = push && ((count_q != 2'd2) || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= 2'd0;
      overflow <= 1'b0;
    end else begin
      if (push && !accept) overflow <= 1'b1;
      case ({accept, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= push_data;
          else                 tail_q <= push_data;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; only the entry order shifts.
          if (count_q == 2'd1) begin
            head_q <= push_data;
          end else begin
            head_q <= tail_q;
            tail_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// Bottom-of-array partial-sum accumulator.
// Deskews the SIZE column partial-sum streams of the systolic array, accumulates
// each aligned row into a ROWS-deep accumulator across K-tiles, and emits rows
// flagged Tile_last through a 2-entry valid/ready FIFO.
//   Partial_Sum_in       : SIZE lanes, lane c arrives c cycles after lane 0
//   Partial_Sum_in_valid : lane-0 valid; Tile_first/Tile_last sampled with it
//   Out_data/Out_valid/Out_ready : finished row stream (same lane packing)
//   Overflow             : sticky, a finished row was dropped on a full FIFO
//   Row_ptr              : accumulator row the next aligned beat targets
module psum_accumulator
  import psum_accumulator_pkg::*;
#(
  parameter int SIZE              = 8,
  parameter int PARTIAL_SUM_WIDTH = psum_width(SIZE),
  parameter int ACC_WIDTH         = acc_width(PARTIAL_SUM_WIDTH),
  parameter int ROWS              = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [SIZE*PARTIAL_SUM_WIDTH-1:0]   Partial_Sum_in,
  input  logic                                Partial_Sum_in_valid,
  input  logic                                Tile_first,
  input  logic                                Tile_last,
  output logic [SIZE*ACC_WIDTH-1:0]           Out_data,
  output logic                                Out_valid,
  input  logic                                Out_ready,
  output logic                                Overflow,
  output logic [$clog2(ROWS)-1:0]             Row_ptr
);

  localparam int PW     = PARTIAL_SUM_WIDTH;
  localparam int AW     = ACC_WIDTH;
  localparam int STAGES = SIZE - 1;
  localparam int RW     = $clog2(ROWS);

  function automatic logic [AW-1:0] sext(input logic [PW-1:0] v);
    return {{(AW-PW){v[PW-1]}}, v};
  endfunction

  // Control delay line: index 0 is the raw input, index STAGES is aligned
  // with the last column lane.
  logic [STAGES:0]         vld_pipe, first_pipe, last_pipe;
  logic [SIZE-1:0][PW-1:0] lane_al;
  logic [SIZE-1:0][AW-1:0] acc_mem [ROWS];
  logic [SIZE-1:0][AW-1:0] acc_rd, row_sum;
  logic                    beat_vld, beat_first, beat_last;

  assign vld_pipe[0]   = Partial_Sum_in_valid;
  assign first_pipe[0] = Tile_first;
  assign last_pipe[0]  = Tile_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe[STAGES:1]   <= '0;
      first_pipe[STAGES:1] <= '0;
      last_pipe[STAGES:1]  <= '0;
    end else begin
      vld_pipe[STAGES:1]   <= vld_pipe[STAGES-1:0];
      first_pipe[STAGES:1] <= first_pipe[STAGES-1:0];
      last_pipe[STAGES:1]  <= last_pipe[STAGES-1:0];
    end
  end

  assign beat_vld   = vld_pipe[STAGES];
  assign beat_first = first_pipe[STAGES];
  assign beat_last  = last_pipe[STAGES];

  // Lane c needs SIZE-1-c stages to line up with the last lane. Lane data is
  // not reset: it is only consumed when the matching valid bit is set.
  for (genvar c = 0; c < SIZE; c++) begin : g_lane
    localparam int D = STAGES - c;
    if (D == 0) begin : g_thru
      assign lane_al[c] = Partial_Sum_in[`PSUM_LANE(c, PW)];
    end else begin : g_dly
      logic [D-1:0][PW-1:0] dly;
      always_ff @(posedge clk) begin
        dly[0] <= Partial_Sum_in[`PSUM_LANE(c, PW)];
        for (int i = 1; i < D; i++) dly[i] <= dly[i-1];
      end
      assign lane_al[c] = dly[D-1];
    end
  end

  assign acc_rd = acc_mem[Row_ptr];

  // Tile_first overwrites the row; otherwise add, wrapping modulo 2^AW.
  always_comb begin
    row_sum = '0;
    for (int c = 0; c < SIZE; c++)
      row_sum[c] = beat_first ? sext(lane_al[c]) : acc_rd[c] + sext(lane_al[c]);
  end

  // Accumulator storage has no reset; a pass always starts with Tile_first.
  always_ff @(posedge clk) begin
    if (beat_vld && !rst) acc_mem[Row_ptr] <= row_sum;
  end

  // Row pointer walks rows on every aligned beat, independent of tile flags.
  always_ff @(posedge clk) begin
    if (rst)
      Row_ptr <= '0;
    else if (beat_vld)
      Row_ptr <= (Row_ptr == RW'(ROWS-1)) ? '0 : Row_ptr + 1'b1;
  end

  // The freshly computed sum (not the stored row) goes to the FIFO, so a
  // finished row leaves on the same edge it is accumulated.
  psum_out_fifo #(
    .WIDTH (SIZE*AW)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (beat_vld && beat_last),
    .push_data (row_sum),
    .out_data  (Out_data),
    .out_valid (Out_valid),
    .out_ready (Out_ready),
    .overflow  (Overflow)
  );

endmodule
